// File: rtl/data_mem_responder.sv
// data_mem_responder
// Fixed-latency data-memory responder for a CPU data port. A request is
// accepted while memReady is high, held in request registers for LATENCY
// cycles and then performed against byte-lane storage. Read data is
// registered on dout and held until the next completed read.
`timescale 1ns/1ps

module data_mem_responder #(
    parameter int WORDS_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] din,
    input  logic [3:0]  byte_select,
    output logic [31:0] dout,
    output logic        memReady,
    output logic        err
);

    localparam int         DEPTH    = 1 << WORDS_LOG2;
    localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [3:0]            cnt_reg;
    logic [WORDS_LOG2-1:0] req_idx_reg;
    logic [31:0]           req_din_reg;
    logic [3:0]            req_bs_reg;
    logic                  req_write_reg;
    logic [31:0]           dout_reg;
    logic                  err_reg;
    logic [31:0]           rd_word;

    logic                  accept;
    logic                  complete;

    // Byte offset and address bits above the storage size are don't-care
    // (addresses wrap modulo the storage size).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:WORDS_LOG2+2], addr[1:0]};

    // Requests are only sampled when ready; WAIT ignores the inputs.
    assign accept   = (state_reg != ST_WAIT) && (ren || wen);
    assign complete = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);

    assign memReady = (state_reg != ST_WAIT);
    assign dout     = dout_reg;
    assign err      = err_reg;

    // Next-state decode: RESP may accept directly for back-to-back traffic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_WAIT;
            ST_WAIT: if (cnt_reg == 4'd0) state_next = ST_RESP;
            ST_RESP: state_next = accept ? ST_WAIT : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Control, request capture, read-data and sticky error registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            req_idx_reg   <= '0;
            req_din_reg   <= 32'd0;
            req_bs_reg    <= 4'd0;
            req_write_reg <= 1'b0;
            dout_reg      <= 32'd0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                req_idx_reg   <= addr[WORDS_LOG2+1:2];
                req_din_reg   <= din;
                req_bs_reg    <= byte_select;
                // A simultaneous read and write is performed as a write.
                req_write_reg <= wen;
                cnt_reg       <= LOAD_VAL;
                if (ren && wen) begin
                    err_reg <= 1'b1;
                end
            end else if (state_reg == ST_WAIT && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (complete && !req_write_reg) begin
                dout_reg <= rd_word;
            end
        end
    end

    // One byte-wide storage array per lane so each lane write is independent.
    // Storage has no reset: contents survive a reset pulse.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Commit the captured lane on completion of an enabled write.
            always_ff @(posedge clock) begin
                if (complete && req_write_reg && req_bs_reg[gi]) begin
                    lane_mem[req_idx_reg] <= req_din_reg[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[req_idx_reg];
        end
    endgenerate

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WORDS_LOG2, default 8; word-index width, storage = 2^WORDS_LOG2 32-bit words.
REQ-002 Parameter LATENCY, default 2; wait cycles between request acceptance and response, legal range 1..15.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 addr  input  32  byte address from the CPU data port.
REQ-006 ren  input  1  read request.
REQ-007 wen  input  1  write request.
REQ-008 din  input  32  write data, already lane-aligned by the CPU.
REQ-009 byte_select  input  4  write byte-lane enables; bit i enables din[8i+7:8i].
REQ-010 dout  output  32  read data, registered.
REQ-011 memReady  output  1  high = responder can accept a request or is presenting a completed response.
REQ-012 err  output  1  sticky flag, set on a simultaneous ren and wen.

Function
REQ-013 States SHALL be IDLE, WAIT and RESP, held in a registered state machine.
REQ-014 memReady SHALL be 1 in IDLE and RESP and 0 in WAIT, decoded from registered state only.
REQ-015 In IDLE or RESP, a rising edge with ren=1 or wen=1 SHALL accept the request.
REQ-016 On acceptance the block SHALL capture into request registers: addr[WORDS_LOG2+1:2] as word index, din, byte_select, and op type.
REQ-017 On acceptance the wait counter SHALL load LATENCY-1 and the state SHALL become WAIT.
REQ-018 addr bits [1:0] and bits above WORDS_LOG2+1 SHALL be ignored; upper addresses alias (wrap) modulo the storage size.
REQ-019 In WAIT the counter SHALL decrement once per cycle.
REQ-020 At the edge where the counter equals 0 in WAIT, the state SHALL become RESP and the captured operation SHALL be performed.
REQ-021 The accept-to-RESP latency SHALL therefore be exactly LATENCY cycles; memReady SHALL be low for exactly LATENCY cycles.
REQ-022 A write SHALL update only the enabled byte lanes of the addressed word; other lanes keep their values.
REQ-023 A write with byte_select=0000 SHALL complete normally and leave memory unchanged.
REQ-024 A write SHALL leave dout unchanged.
REQ-025 A read SHALL load dout with the full addressed word, reflecting every write completed earlier.
REQ-026 dout SHALL hold its value until the next completed read.
REQ-027 In RESP with no new request, the state SHALL return to IDLE on the next edge.
REQ-028 Requests present during WAIT SHALL be ignored; the inputs are not re-sampled.
REQ-029 If ren=1 and wen=1 at acceptance, the request SHALL be treated as a write and err SHALL be set to 1.
REQ-030 err SHALL remain set until reset.
REQ-031 Back-to-back requests SHALL be accepted from RESP with no IDLE cycle in between, giving one request per LATENCY+1 cycles.

Reset
REQ-032 reset=0 SHALL asynchronously force state=IDLE, memReady=1, dout=0, err=0, counter=0 and request registers to 0.
REQ-033 Reset SHALL NOT clear the storage array.
REQ-034 Reset asserted during WAIT SHALL abort the pending operation; no memory write occurs.
REQ-035 After reset release, the first rising edge with a request SHALL be accepted normally.

Verification
REQ-036 LATENCY=2: write addr=0x10, din=0xDEADBEEF, bs=1111; then read 0x10 -> memReady low 2 cycles per request; dout=0xDEADBEEF in the read's RESP cycle.
REQ-037 Word 0x10 holds 0xDEADBEEF; write din=0x0000AA00, bs=0010; read 0x10 -> dout=0xDEADAAEF.
REQ-038 WORDS_LOG2=8: write 0x12345678 to addr=0x400; read addr=0x0 -> dout=0x12345678 (wrap-around); read addr=0x3 -> same word.
REQ-039 ren=wen=1, addr=0x20, din=0x55, bs=0001 -> write performed, err=1 and stays 1; a later read of 0x20 returns 0x55 in byte 0.
REQ-040 Reset pulsed in the 2nd WAIT cycle of a write to 0x30 -> memReady=1, dout=0, err=0 immediately; a following read of 0x30 returns the pre-write value.
REQ-041 Requests held continuously for 10 transactions, LATENCY=3 -> one acceptance every 4 cycles; ren toggling during WAIT causes no extra acceptance.
